alu_op_issue: RTL and testbench
===============================

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 Parameter: WIDTH, default 8, data width of operands and result.
REQ-002 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  instruction present on in_opcode/in_a/in_b.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 in_opcode  input  4  {sel[1:0], sub[1:0]}.
REQ-008 in_a, in_b  input  WIDTH  operands.
REQ-009 ctrl  output  2  select to the ALU result mux: 00 compare, 01 andornot, 10 addsub, 11 idle/none.
REQ-010 sub_op  output  2  operation within the selected unit.
REQ-011 op_a, op_b  output  WIDTH  registered operands to the ALU units.
REQ-012 s  input  WIDTH  result returned by the ALU result mux.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_result  output  WIDTH  captured result.
REQ-016 out_err  output  1  the instruction was illegal; qualified by out_valid.
REQ-017 op_count  output  8  count of legal operations completed.

Function
REQ-018 FSM states are IDLE, ISSUE, CAPTURE, HOLD.
REQ-019 IDLE: in_ready=1; when in_valid=1, latch opcode/operands and decode; go to ISSUE for legal opcodes, or to HOLD with out_err=1 and out_result=0 for illegal ones.
REQ-020 Legal opcodes:
- sel=00 with sub 00 eq, 01 lt, 10 gt.
- sel=01 with sub 00 and, 01 or, 10 not.
- sel=10 with sub 00 add, 01 sub.
REQ-021 Illegal opcodes: sel=11, sub=11, or opcode 4'b1010.
REQ-022 ISSUE (one cycle): ctrl=sel, sub_op=sub, op_a/op_b=latched operands; go to CAPTURE.
REQ-023 CAPTURE: ctrl/sub_op/operands held; out_result<=s, out_err<=0, op_count increments; go to HOLD.
REQ-024 Latency: an instruction accepted at edge N gives out_valid=1 after edge N+3 for legal opcodes and after edge N+1 for illegal ones.
REQ-025 HOLD: out_valid=1 and outputs stable until out_ready=1; on that edge go to IDLE and out_valid=0.
REQ-026 in_ready=0 in ISSUE, CAPTURE and HOLD; there is no pass-through from HOLD to accept.
REQ-027 ctrl=11 and sub_op=00 in every state except ISSUE and CAPTURE.
REQ-028 op_count wraps from 255 to 0 and does not count illegal opcodes.
REQ-029 in_valid=1 while in_ready=0 is ignored, with no side effects.
REQ-030 out_ready=1 while out_valid=0 has no effect.

Reset
REQ-031 rst=1 at a clock edge forces:
- state IDLE, ctrl=11, sub_op=00, op_a=op_b=0;
- out_valid=0, out_result=0, out_err=0, op_count=0.
REQ-032 rst in any state, including mid-ISSUE/CAPTURE, discards the in-flight instruction with no result emitted; rst has priority over all other inputs.
REQ-033 in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-034 A shared package alu_pkg holds the sel encodings (SEL_CMP, SEL_LOGIC, SEL_ADDSUB, SEL_NONE), the sub-op encodings, and the FSM state type.
REQ-035 One sub-module, alu_op_decode, is natural: combinational opcode to {sel, sub, illegal}.
REQ-036 All outputs are registered.

Verification
REQ-037 Legal op: opcode 1000, a=8'd5, b=8'd3, bench mux returns a+b, out_ready=1 -> ctrl=10 and sub_op=00 during ISSUE/CAPTURE; out_valid after 3 edges with out_result=8, out_err=0, op_count=1.
REQ-038 Illegal op: opcode 1100 -> out_valid after 1 edge with out_err=1 and out_result=0; ctrl never leaves 11; op_count unchanged.
REQ-039 Backpressure: out_ready=0 for 5 cycles after an AND of 8'hF0 and 8'h3C -> out_result=8'h30 stable, in_ready=0, a second in_valid ignored; release -> IDLE.
REQ-040 Reset mid-op: rst asserted in CAPTURE -> next cycle all outputs are at reset values, no out_valid, op_count=0.
REQ-041 Wrap: 256 back-to-back legal ops -> op_count returns to 0; every result is accepted exactly once.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU issue block.
package alu_pkg;
   localparam logic [1:0] SEL_CMP    = 2'b00;
   localparam logic [1:0] SEL_LOGIC  = 2'b01;
   localparam logic [1:0] SEL_ADDSUB = 2'b10;
   localparam logic [1:0] SEL_NONE   = 2'b11;
   localparam logic [1:0] SUB_EQ  = 2'b00;
   localparam logic [1:0] SUB_LT  = 2'b01;
   localparam logic [1:0] SUB_GT  = 2'b10;
   localparam logic [1:0] SUB_AND = 2'b00;
   localparam logic [1:0] SUB_OR  = 2'b01;
   localparam logic [1:0] SUB_NOT = 2'b10;
   localparam logic [1:0] SUB_ADD = 2'b00;
   localparam logic [1:0] SUB_SUB = 2'b01;
   localparam logic [1:0] SUB_BAD = 2'b11;
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: splits an opcode into unit select and sub-op, flagging illegal codes.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [3:0] opcode_i,
   output logic [1:0] sel_o,
   output logic [1:0] sub_o,
   output logic       illegal_o
);
   assign sel_o     = opcode_i[3:2];
   assign sub_o     = opcode_i[1:0];
   assign illegal_o = (sel_o == SEL_NONE) || (sub_o == SUB_BAD) ||
                      (sel_o == SEL_ADDSUB && sub_o == 2'b10);
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: accepts one instruction, drives the ALU mux, captures and holds the result.
module alu_op_issue
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [1:0]       ctrl,
   output logic [1:0]       sub_op,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_err,
   output logic [7:0]       op_count
);
   state_t           state_q;
   logic             in_ready_q, out_valid_q, out_err_q;
   logic [1:0]       ctrl_q, sub_op_q, sel, sub;
   logic [WIDTH-1:0] op_a_q, op_b_q, out_result_q;
   logic [7:0]       op_count_q;
   logic             illegal;

   alu_op_decode u_decode (
      .opcode_i  (in_opcode),
      .sel_o     (sel),
      .sub_o     (sub),
      .illegal_o (illegal)
   );

   // out_valid rises one edge after HOLD is entered, so the legal path spans three edges
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         ctrl_q       <= SEL_NONE;
         sub_op_q     <= SUB_EQ;
         op_a_q       <= '0;
         op_b_q       <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_err_q    <= 1'b0;
         op_count_q   <= 8'd0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               in_ready_q <= 1'b0;
               op_a_q     <= in_a;
               op_b_q     <= in_b;
               out_err_q  <= illegal;
               if (illegal) begin
                  out_result_q <= '0;
                  state_q      <= HOLD;
               end else begin
                  ctrl_q   <= sel;
                  sub_op_q <= sub;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: state_q <= CAPTURE;
            CAPTURE: begin
               out_result_q <= s;
               out_err_q    <= 1'b0;
               op_count_q   <= op_count_q + 8'd1;
               ctrl_q       <= SEL_NONE;
               sub_op_q     <= SUB_EQ;
               state_q      <= HOLD;
            end
            HOLD: if (out_valid_q && out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end else begin
               out_valid_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign ctrl       = ctrl_q;
   assign sub_op     = sub_op_q;
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_err    = out_err_q;
   assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: randomized self-checking bench with an opcode-level reference model.
module tb_alu_op_issue;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, out_err;
   logic [3:0] in_opcode = 4'h0;
   logic [7:0] in_a = 8'h00, in_b = 8'h00, op_a, op_b, s, out_result, op_count;
   logic [1:0] ctrl, sub_op;
   logic [7:0] exp_count = 8'd0;
   logic [3:0] legal_ops [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
   int         pass_cnt = 0, total = 0;

   always #5 clk = ~clk;

   alu_op_issue #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .ctrl(ctrl),
      .sub_op(sub_op), .op_a(op_a), .op_b(op_b), .s(s), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
      .op_count(op_count)
   );

   // environment ALU: the result mux the block steers
   function automatic logic [7:0] alu_mux(input logic [1:0] c, input logic [1:0] sb,
                                          input logic [7:0] a, input logic [7:0] b);
      if (c == 2'b00) return (sb == 2'b00) ? {7'd0, a == b} : (sb == 2'b01) ? {7'd0, a < b} :
                             (sb == 2'b10) ? {7'd0, a > b} : 8'h00;
      if (c == 2'b01) return (sb == 2'b00) ? (a & b) : (sb == 2'b01) ? (a | b) :
                             (sb == 2'b10) ? ~a : 8'h00;
      if (c == 2'b10) return (sb == 2'b00) ? a + b : (sb == 2'b01) ? a - b : 8'h00;
      return 8'h00;
   endfunction

   always_comb s = alu_mux(ctrl, sub_op, op_a, op_b);

   function automatic bit is_legal(input logic [3:0] op);
      return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
   endfunction

   function automatic logic [7:0] ref_result(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      case (op)
         4'h0: return (a == b) ? 8'd1 : 8'd0;
         4'h1: return (a < b) ? 8'd1 : 8'd0;
         4'h2: return (a > b) ? 8'd1 : 8'd0;
         4'h4: return a & b;
         4'h5: return a | b;
         4'h6: return ~a;
         4'h8: return a + b;
         4'h9: return a - b;
         default: return 8'd0;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input bit poke, input bit early);
      bit         legal = is_legal(op);
      logic [7:0] exp = ref_result(op, a, b);
      @(negedge clk);
      in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; out_ready = early;
      @(posedge clk); #1 in_valid = 1'b0;
      if (legal) begin
         total++;
         if ({in_ready, out_valid, ctrl, sub_op, op_a, op_b} !== {2'b00, op, a, b})
            $display("FAIL issue op=%h: got rdy=%b v=%b ctrl=%b sub=%b a=%h b=%h want 0 0 %b %h %h",
                     op, in_ready, out_valid, ctrl, sub_op, op_a, op_b, op, a, b);
         else pass_cnt++;
         @(posedge clk); #1;
         total++;
         if ({in_ready, out_valid, ctrl, sub_op, op_a, op_b} !== {2'b00, op, a, b})
            $display("FAIL capture op=%h: got v=%b ctrl=%b sub=%b want 0 %b", op, out_valid, ctrl, sub_op, op);
         else pass_cnt++;
         @(posedge clk); #1;
         total++;
         if ({in_ready, out_valid, ctrl, sub_op} !== 6'b001100)
            $display("FAIL hold_entry op=%h: got rdy=%b v=%b ctrl=%b sub=%b want 0 0 11 00",
                     op, in_ready, out_valid, ctrl, sub_op);
         else pass_cnt++;
         exp_count++;
      end else begin
         total++;
         if ({in_ready, out_valid, ctrl, sub_op} !== 6'b001100)
            $display("FAIL illegal_accept op=%h: got rdy=%b v=%b ctrl=%b sub=%b want 0 0 11 00",
                     op, in_ready, out_valid, ctrl, sub_op);
         else pass_cnt++;
      end
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, out_err, out_result, op_count, ctrl} !== {2'b10, !legal, exp, exp_count, 2'b11})
         $display("FAIL result op=%h: got v=%b rdy=%b err=%b res=%h cnt=%0d want 1 0 %b %h %0d",
                  op, out_valid, in_ready, out_err, out_result, op_count, !legal, exp, exp_count);
      else pass_cnt++;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = poke; in_opcode = 4'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
         @(posedge clk); #1;
         total++;
         if ({out_valid, in_ready, out_err, out_result, op_count, ctrl} !== {2'b10, !legal, exp, exp_count, 2'b11})
            $display("FAIL backpressure op=%h cyc=%0d: got v=%b rdy=%b err=%b res=%h cnt=%0d want 1 0 %b %h %0d",
                     op, i, out_valid, in_ready, out_err, out_result, op_count, !legal, exp, exp_count);
         else pass_cnt++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready, ctrl, sub_op} !== 6'b011100)
         $display("FAIL release op=%h: got v=%b rdy=%b ctrl=%b sub=%b want 0 1 11 00",
                  op, out_valid, in_ready, ctrl, sub_op);
      else pass_cnt++;
   endtask

   task automatic apply_reset();
      @(negedge clk); rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      exp_count = 8'd0;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({in_ready, out_valid, out_err, ctrl, sub_op, op_a, op_b, out_result, op_count} !==
          {3'b100, 4'b1100, 32'd0})
         $display("FAIL reset: got rdy=%b v=%b err=%b ctrl=%b sub=%b a=%h b=%h res=%h cnt=%0d want 1 0 0 11 00 0 0 0 0",
                  in_ready, out_valid, out_err, ctrl, sub_op, op_a, op_b, out_result, op_count);
      else pass_cnt++;
   endtask

   task automatic test_legal();
      run_op(4'h8, 8'd5, 8'd3, 0, 1'b0, 1'b1);
      total++;
      if ({out_result, op_count} !== {8'd8, 8'd1})
         $display("FAIL legal_add: got res=%0d cnt=%0d want 8 1", out_result, op_count);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      run_op(4'hC, 8'h12, 8'h34, 0, 1'b0, 1'b0);
      run_op(4'hA, 8'h55, 8'h66, 2, 1'b0, 1'b1);
      run_op(4'h3, 8'h77, 8'h88, 1, 1'b1, 1'b0);
      run_op(4'hF, 8'h01, 8'h02, 0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_op(4'h4, 8'hF0, 8'h3C, 5, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++)
         run_op(4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk); in_valid = 1'b1; in_opcode = 4'h8; in_a = 8'h21; in_b = 8'h43;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_count = 8'd0;
      total++;
      if ({in_ready, out_valid, out_err, ctrl, sub_op, op_a, op_b, out_result, op_count} !==
          {3'b100, 4'b1100, 32'd0})
         $display("FAIL reset_mid: got rdy=%b v=%b err=%b ctrl=%b sub=%b a=%h b=%h res=%h cnt=%0d want reset values",
                  in_ready, out_valid, out_err, ctrl, sub_op, op_a, op_b, out_result, op_count);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({out_valid, in_ready, op_count} !== {2'b01, 8'd0})
            $display("FAIL reset_mid_quiet cyc=%0d: got v=%b rdy=%b cnt=%0d want 0 1 0",
                     i, out_valid, in_ready, op_count);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back_wrap();
      apply_reset();
      for (int n = 0; n < 256; n++)
         run_op(legal_ops[$urandom_range(0, 7)], 8'($urandom), 8'($urandom), 0, 1'b0, 1'b1);
      total++;
      if (op_count !== 8'd0)
         $display("FAIL wrap: got cnt=%0d want 0", op_count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_legal();
      test_illegal();
      test_backpressure();
      test_random();
      test_reset_mid_op();
      test_back_to_back_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
